// File: rtl/mux16_rr_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Shared constants and FSM state type for the 16:1 bit-mux
//               round-robin scheduler slice.
// Contents    : MUX_N      - number of mux inputs / requesters
//               MUX_SEL_W  - mux select width
//               state_t    - scheduler FSM states (IDLE, GRANT)
// Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    localparam int MUX_N     = 16;
    localparam int MUX_SEL_W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mux16_rr_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : mux16_rr_sched_if
// Description : Requester-side bus of the round-robin mux scheduler.
// Signals     : req[15:0]       - per-requester level request
//               data_in[15:0]   - per-requester serial data bit
//               burst_len       - grant length minus one, sampled at grant
//               sel[3:0]        - registered mux select (current grantee)
//               grant[15:0]     - registered one-hot grant, zero when idle
//               valid           - registered, high while a grant is active
//               data_out        - selected bit gated by valid
// Modports    : master - requester/consumer side, slave - scheduler side
// Revision    : 1.0 - initial release
// ============================================================================
interface mux16_rr_sched_if
    import mux_pkg::*;
#(
    parameter int BURST_W = 4
);

    logic [MUX_N-1:0]     req;
    logic [MUX_N-1:0]     data_in;
    logic [BURST_W-1:0]   burst_len;
    logic [MUX_SEL_W-1:0] sel;
    logic [MUX_N-1:0]     grant;
    logic                 valid;
    logic                 data_out;

    modport master (
        output req,
        output data_in,
        output burst_len,
        input  sel,
        input  grant,
        input  valid,
        input  data_out
    );

    modport slave (
        input  req,
        input  data_in,
        input  burst_len,
        output sel,
        output grant,
        output valid,
        output data_out
    );

endinterface
`default_nettype wire

// File: rtl/mux16_rr_sched_mux162.sv
`default_nettype none
// ============================================================================
// Module      : mux162
// Description : 16:1 single-bit multiplexer shared by the scheduler.
// Ports       : data_in[15:0] - data bits
//               sel[3:0]      - select index
//               data_out      - data_in[sel]
// Revision    : 1.0 - initial release
// ============================================================================
module mux162 (
    input  wire logic [15:0] data_in,
    input  wire logic [3:0]  sel,
    output logic             data_out
);

    assign data_out = data_in[sel];

endmodule
`default_nettype wire

// File: rtl/mux16_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : mux16_rr_sched
// Description : Round-robin scheduler sharing one mux162 among 16 requesters.
//               Grants one requester at a time for burst_len+1 cycles (or
//               until it drops req), re-arbitrating on the release edge so
//               back-to-back grants carry no idle cycle.
// Ports       : clk - clock, rising edge
//               rst - asynchronous active-high reset
//               bus - mux16_rr_sched_if.slave (req, data_in, burst_len in;
//                     sel, grant, valid, data_out out)
// Revision    : 1.0 - initial release
// ============================================================================
module mux16_rr_sched
    import mux_pkg::*;
#(
    parameter int N_REQ   = MUX_N,
    parameter int BURST_W = 4
)(
    input  wire logic         clk,
    input  wire logic         rst,
    mux16_rr_sched_if.slave   bus
);

    // Returns {found, index} of the first set bit of req scanning from ptr
    // upward with wrap. The loop runs from the farthest offset down to the
    // nearest so the last hit (lowest offset from ptr) wins without a break.
    function automatic logic [MUX_SEL_W:0] f_arb(
        input logic [N_REQ-1:0]     req,
        input logic [MUX_SEL_W-1:0] ptr
    );
        logic [MUX_SEL_W:0]   res;
        logic [MUX_SEL_W-1:0] idx;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr + MUX_SEL_W'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic [MUX_SEL_W-1:0] r_ptr;
    logic [MUX_SEL_W-1:0] w_ptr_nxt;
    logic [BURST_W-1:0]   r_cnt;
    logic [BURST_W-1:0]   w_cnt_nxt;
    logic [MUX_SEL_W-1:0] r_sel;
    logic [MUX_SEL_W-1:0] w_sel_nxt;
    logic [N_REQ-1:0]     r_grant;
    logic [N_REQ-1:0]     w_grant_nxt;
    logic                 r_valid;
    logic                 w_valid_nxt;

    logic                 w_release;
    logic [MUX_SEL_W-1:0] w_arb_ptr;
    logic [MUX_SEL_W:0]   w_arb;
    logic                 w_mux_out;

    assign w_release = (r_cnt == '0) || !bus.req[r_sel];

    // In GRANT the arbitration always uses the post-release pointer; it is
    // only consumed when w_release is set, so the just-released requester
    // lands at the lowest priority.
    assign w_arb_ptr = (r_state == GRANT) ? (r_sel + 1'b1) : r_ptr;
    assign w_arb     = f_arb(bus.req, w_arb_ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_grant <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_grant <= w_grant_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_grant_nxt = r_grant;
        w_valid_nxt = r_valid;

        case (r_state)
            IDLE: begin
                if (w_arb[MUX_SEL_W]) begin
                    w_state_nxt = GRANT;
                    w_sel_nxt   = w_arb[MUX_SEL_W-1:0];
                    w_grant_nxt = N_REQ'(1) << w_arb[MUX_SEL_W-1:0];
                    w_cnt_nxt   = bus.burst_len;
                    w_valid_nxt = 1'b1;
                end
            end
            GRANT: begin
                if (!w_release) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_ptr_nxt = w_arb_ptr;
                    if (w_arb[MUX_SEL_W]) begin
                        w_sel_nxt   = w_arb[MUX_SEL_W-1:0];
                        w_grant_nxt = N_REQ'(1) << w_arb[MUX_SEL_W-1:0];
                        w_cnt_nxt   = bus.burst_len;
                    end else begin
                        // sel deliberately holds its last value when idle
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                        w_valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    mux162 u_mux162 (
        .data_in  (bus.data_in),
        .sel      (r_sel),
        .data_out (w_mux_out)
    );

    assign bus.sel      = r_sel;
    assign bus.grant    = r_grant;
    assign bus.valid    = r_valid;
    assign bus.data_out = r_valid & w_mux_out;

endmodule
`default_nettype wire

// File: tb/tb_mux16_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux16_rr_sched
// Description : Self-checking bench for mux16_rr_sched. A behavioural model
//               pushes the expected grant state at each clock edge and the
//               DUT outputs are popped and compared shortly after the edge;
//               directed checks cover reset, wrap, early release, burst
//               latching and idle return.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux16_rr_sched;

    typedef struct {
        logic [3:0]  sel;
        logic [15:0] grant;
        logic        valid;
    } exp_t;

    logic clk;
    logic rst;

    mux16_rr_sched_if #(.BURST_W(4)) bus ();

    mux16_rr_sched #(
        .N_REQ   (16),
        .BURST_W (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    n_checks;
    int    n_err;
    exp_t  sb[$];

    // Behavioural model state
    int          m_ptr;
    int          m_cnt;
    int          m_sel;
    logic [15:0] m_grant;
    logic        m_valid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int m_arb(input logic [15:0] r, input int p);
        for (int k = 0; k < 16; k++) begin
            if (r[(p + k) % 16]) return (p + k) % 16;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_cnt   = 0;
        m_sel   = 0;
        m_grant = '0;
        m_valid = 1'b0;
    endtask

    task automatic model_load(input int w);
        m_sel   = w;
        m_grant = 16'(1) << w;
        m_cnt   = int'(bus.burst_len);
        m_valid = 1'b1;
    endtask

    task automatic model_edge();
        int w;
        if (!m_valid) begin
            w = m_arb(bus.req, m_ptr);
            if (w >= 0) model_load(w);
        end else if (m_cnt == 0 || !bus.req[m_sel]) begin
            m_ptr = (m_sel + 1) % 16;
            w = m_arb(bus.req, m_ptr);
            if (w >= 0) begin
                model_load(w);
            end else begin
                m_valid = 1'b0;
                m_grant = '0;
            end
        end else begin
            m_cnt = m_cnt - 1;
        end
    endtask

    // One clock edge: model pushes the expectation, DUT result is popped
    // and compared 1 time unit after the edge.
    task automatic step();
        exp_t e;
        @(posedge clk);
        model_edge();
        e.sel   = 4'(m_sel);
        e.grant = m_grant;
        e.valid = m_valid;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        chk("sb_sel",   32'(bus.sel),      32'(e.sel));
        chk("sb_grant", 32'(bus.grant),    32'(e.grant));
        chk("sb_valid", 32'(bus.valid),    32'(e.valid));
        chk("sb_dout",  32'(bus.data_out), 32'(e.valid & bus.data_in[e.sel]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        n_checks      = 0;
        n_err         = 0;
        rst           = 1'b0;
        bus.req       = '0;
        bus.data_in   = '0;
        bus.burst_len = '0;
        model_reset();

        // Reset state
        #2 rst = 1'b1;
        #10;
        chk("rst_sel",   32'(bus.sel),      32'd0);
        chk("rst_grant", 32'(bus.grant),    32'd0);
        chk("rst_valid", 32'(bus.valid),    32'd0);
        chk("rst_dout",  32'(bus.data_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single requester, continuous re-grant
        bus.req       = 16'h0020;
        bus.burst_len = 4'd2;
        bus.data_in   = 16'h0020;
        step();
        chk("single_sel",   32'(bus.sel),   32'd5);
        chk("single_grant", 32'(bus.grant), 32'h0020);
        repeat (8) begin
            step();
            chk("single_valid", 32'(bus.valid),    32'd1);
            chk("single_dout",  32'(bus.data_out), 32'd1);
        end

        // Asynchronous reset mid-burst (sel=5), no clock edge involved
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.valid),    32'd0);
        chk("arst_grant", 32'(bus.grant),    32'd0);
        chk("arst_dout",  32'(bus.data_out), 32'd0);
        chk("arst_sel",   32'(bus.sel),      32'd0);
        model_reset();
        @(negedge clk);
        rst     = 1'b0;
        bus.req = 16'h0001;
        step();
        chk("arst_regrant_sel",   32'(bus.sel),   32'd0);
        chk("arst_regrant_grant", 32'(bus.grant), 32'h0001);

        // Round robin with wrap 0 -> 15 -> 0
        do_reset();
        bus.req       = 16'h8001;
        bus.burst_len = 4'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_sel",   32'(bus.sel),   (i % 2 == 0) ? 32'd0 : 32'd15);
            chk("rr_grant", 32'(bus.grant), (i % 2 == 0) ? 32'h0001 : 32'h8000);
        end

        // Early release of requester 1 after two granted cycles
        do_reset();
        bus.req       = 16'h0006;
        bus.burst_len = 4'd7;
        step();
        step();
        bus.req = 16'h0004;
        step();
        chk("early_sel",   32'(bus.sel),   32'd2);
        chk("early_grant", 32'(bus.grant), 32'h0004);
        bus.req = 16'h0006;
        n = 1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.sel != 4'd2) break;
            n++;
        end
        chk("early_len", 32'(n), 32'd8);

        // burst_len latched at grant time
        do_reset();
        bus.req       = 16'h0003;
        bus.burst_len = 4'd3;
        step();
        bus.burst_len = 4'd0;
        n = 1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.sel != 4'd0) break;
            n++;
        end
        chk("latch_len",    32'(n),       32'd4);
        chk("latch_next",   32'(bus.sel), 32'd1);
        step();
        chk("latch_short",  32'(bus.sel), 32'd0);

        // Return to idle when the only requester drops
        do_reset();
        bus.req       = 16'h0020;
        bus.data_in   = 16'h0020;
        bus.burst_len = 4'd1;
        repeat (3) step();
        bus.req = 16'h0000;
        step();
        chk("idle_valid", 32'(bus.valid),    32'd0);
        chk("idle_grant", 32'(bus.grant),    32'd0);
        chk("idle_dout",  32'(bus.data_out), 32'd0);
        chk("idle_sel",   32'(bus.sel),      32'd5);

        // Random traffic against the model
        do_reset();
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.req = 16'($urandom & $urandom & $urandom);
            end
            bus.data_in   = 16'($urandom);
            bus.burst_len = 4'($urandom_range(0, 3));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
